md_ctrl: RTL
============

# md_ctrl

Issue and hazard controller for the HI/LO multiply/divide unit of the pipelined MIPS core. It sits beside the E stage and drives the unit's start, operation-select and HI/LO write-enable inputs from decoded E-stage instruction flags. It models the unit's fixed multiply and divide latencies with its own state machine and down-counter. It raises the D-stage stall whenever a HI/LO-class instruction would read or write the unit before the unit's result is ready.

## Interface
Parameters:
- MUL_LAT, default 5: busy cycles after a mult/multu/madd issue (1..31).
- DIV_LAT, default 10: busy cycles after a div/divu issue (1..31).

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  one clock domain; asynchronous, active-low reset.
- d_md_use  in  1  the D-stage instruction is mult/multu/div/divu/madd/mfhi/mflo/mthi/mtlo.
- e_start  in  1  the E-stage instruction is mult/multu/div/divu/madd.
- e_sel  in  3  operation code for the E-stage instruction: 0 mult, 1 multu, 2 div, 3 divu, 4 madd; values 5..7 are reserved.
- e_mthi  in  1  the E-stage instruction is mthi.
- e_mtlo  in  1  the E-stage instruction is mtlo.
- e_flush  in  1  the E-stage instruction is squashed this cycle.
- md_start  out  1  start pulse to the unit; combinational.
- md_sel  out  3  operation select to the unit; equals e_sel.
- hi_en  out  1  HI write enable; combinational.
- lo_en  out  1  LO write enable; combinational.
- busy  out  1  the unit is computing; registered.
- busy_cnt  out  5  remaining busy cycles; registered.
- stall  out  1  freeze the F and D stages and insert a bubble into E; combinational.
- err  out  1  sticky protocol-violation flag; registered.

## Operation
- States: IDLE, MUL, DIV. Reset values: state IDLE, busy_cnt 0, busy 0, err 0.
- issue = e_start & ~e_flush & ~busy & (e_sel <= 4).
- md_start = issue.
- hi_en = e_mthi & ~e_flush & ~busy. lo_en = e_mtlo & ~e_flush & ~busy. Both may be high in the same cycle.
- On the edge after issue:
  - e_sel of 0, 1 or 4: go to MUL and load busy_cnt = MUL_LAT.
  - e_sel of 2 or 3: go to DIV and load busy_cnt = DIV_LAT.
- In MUL or DIV, busy_cnt decrements by 1 on each edge. When busy_cnt goes from 1 to 0, return to IDLE.
- busy = (state != IDLE). busy_cnt is nonzero exactly when busy is high.
- stall = d_md_use & (busy | issue).
- mfhi and mflo need no handling here; the stall keeps them in D until the result is final.
- err is set, and stays set until reset, when any of the following occur with e_flush low:
  - e_start, e_mthi or e_mtlo while busy is high; the operation is dropped and no pulse is emitted.
  - e_start with e_sel of 5..7; no issue.
  - e_start together with e_mthi or e_mtlo in the same cycle; the issue still proceeds.
- A flushed E-stage instruction never issues, never writes HI/LO and never sets err.
- A D-stage instruction that is not a HI/LO user never stalls because of this block.

## Timing
- An issue at cycle T puts busy high for cycles T+1 through T+LAT, where LAT is MUL_LAT or DIV_LAT.
- stall is high for cycles T through T+LAT whenever d_md_use is high.
- A dependent HI/LO instruction reaches E at cycle T+LAT+2 at the earliest. mfhi/mflo read the final value there.
- A back-to-back issue is legal at cycle T+LAT+1, the first cycle busy is low.
- Only one operation is ever in flight; there is no queueing.
- Reset going low at any point, including mid-operation, immediately forces the reset values on all registered outputs. Combinational outputs follow their inputs. The unit's own reset clears HI and LO in the same event.
- After reset is released, the first edge with a valid e_start issues normally.

## Test plan
- mult issue: reset released; e_start=1, e_sel=0 at cycle 0 with d_md_use=1 from cycle 0. Required: md_start=1 at cycle 0; busy=1 for cycles 1-5 with busy_cnt stepping 5,4,3,2,1; stall=1 for cycles 0-5; busy=0 and stall=0 at cycle 6.
- divu issue: e_sel=3 issued, with d_md_use held at 0 throughout. Required: busy high for exactly 10 cycles; stall stays 0 throughout.
- Protocol violations:
  - e_start while busy_cnt=3. Required: md_start=0, err=1 from the next cycle and it stays 1; the busy sequence is unchanged.
  - e_start with e_sel=6. Required: no issue and err=1.
- mthi+mtlo: e_mthi=1 and e_mtlo=1 together while idle. Required: hi_en=1 and lo_en=1 in the same cycle, busy stays 0.
  - Repeat with e_flush=1. Required: all outputs stay 0 and err stays 0.
- Reset mid-operation: madd issued, then reset pulled low at busy_cnt=2. Required: busy, busy_cnt and err go to 0 immediately without waiting for a clock edge. After release, a mult issues and busy lasts 5 cycles.
- Back-to-back: mult issued at cycle 0, then div issued at cycle 6. Required: md_start=1 at cycles 0 and 6; busy high for cycles 1-5 and 7-16; err stays 0.

Source files
------------

// File: rtl/md_ctrl.sv
// -----------------------------------------------------------------------------
// md_ctrl
//
// Issue and hazard controller for the HI/LO multiply/divide unit. It sits
// beside the E stage and turns the decoded E-stage flags into the unit's
// start pulse, operation select and HI/LO write enables. The unit's fixed
// multiply and divide latencies are tracked here with a small state machine
// and a down-counter, and the D-stage stall is raised while the unit's result
// is not yet final.
//
// Parameters
//   MUL_LAT   busy cycles after a mult/multu/madd issue (1..31)
//   DIV_LAT   busy cycles after a div/divu issue (1..31)
//
// Ports
//   clk       in   pipeline clock, rising edge
//   reset     in   asynchronous, active-low reset
//   d_md_use  in   D-stage instruction is a HI/LO user
//   e_start   in   E-stage instruction is mult/multu/div/divu/madd
//   e_sel     in   E-stage operation code (0 mult, 1 multu, 2 div, 3 divu, 4 madd)
//   e_mthi    in   E-stage instruction is mthi
//   e_mtlo    in   E-stage instruction is mtlo
//   e_flush   in   E-stage instruction is squashed this cycle
//   md_start  out  start pulse to the unit (combinational)
//   md_sel    out  operation select to the unit (copy of e_sel)
//   hi_en     out  HI write enable (combinational)
//   lo_en     out  LO write enable (combinational)
//   busy      out  unit is computing (registered)
//   busy_cnt  out  remaining busy cycles (registered)
//   stall     out  freeze F/D and insert a bubble into E (combinational)
//   err       out  sticky protocol-violation flag (registered)
// -----------------------------------------------------------------------------
module md_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_md_use,
    input  logic       e_start,
    input  logic [2:0] e_sel,
    input  logic       e_mthi,
    input  logic       e_mtlo,
    input  logic       e_flush,
    output logic       md_start,
    output logic [2:0] md_sel,
    output logic       hi_en,
    output logic       lo_en,
    output logic       busy,
    output logic [4:0] busy_cnt,
    output logic       stall,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam logic [4:0] MUL_CNT = 5'(MUL_LAT);
    localparam logic [4:0] DIV_CNT = 5'(DIV_LAT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_cnt;
    logic [4:0] w_cnt_nxt;
    logic       r_busy;
    logic       r_err;
    logic       w_err_nxt;

    logic       w_sel_ok;
    logic       w_is_div;
    logic       w_issue;
    logic       w_mt_any;
    logic       w_viol;

    // Codes 5..7 are reserved and never start the unit.
    assign w_sel_ok = (e_sel <= 3'd4);
    assign w_is_div = (e_sel == 3'd2) || (e_sel == 3'd3);
    assign w_issue  = e_start & ~e_flush & ~r_busy & w_sel_ok;
    assign w_mt_any = e_mthi | e_mtlo;

    // Any of these, on an unflushed E-stage instruction, latches err.
    // A busy-time request is simply dropped: issue/hi_en/lo_en are all
    // gated by ~r_busy, so nothing reaches the unit.
    assign w_viol = ~e_flush & ( (r_busy & (e_start | w_mt_any))
                               | (e_start & ~w_sel_ok)
                               | (e_start & w_mt_any) );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err | w_viol;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    if (w_is_div) begin
                        w_state_nxt = DIV;
                        w_cnt_nxt   = DIV_CNT;
                    end else begin
                        w_state_nxt = MUL;
                        w_cnt_nxt   = MUL_CNT;
                    end
                end
            end
            MUL, DIV: begin
                // Counter reaches 0 on the same edge the state returns to
                // IDLE, keeping busy_cnt != 0 exactly while busy.
                w_cnt_nxt = r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_err   <= w_err_nxt;
        end
    end

    assign md_start = w_issue;
    assign md_sel   = e_sel;
    assign hi_en    = e_mthi & ~e_flush & ~r_busy;
    assign lo_en    = e_mtlo & ~e_flush & ~r_busy;
    assign busy     = r_busy;
    assign busy_cnt = r_cnt;
    // Stalling in the issue cycle too keeps a dependent HI/LO user in D
    // until the cycle after the result becomes final.
    assign stall    = d_md_use & (r_busy | w_issue);
    assign err      = r_err;

endmodule
